// File: rtl/axi_master_bridge.sv
// Bridges CPU line requests onto AXI: writes are queued in a small FIFO and
// issued as bursts, reads run one burst at a time and are reassembled into a line.
module axi_master_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LINE_W      = 128,
  parameter int ID_W        = 4,
  parameter int WFIFO_DEPTH = 4,
  parameter logic [ID_W-1:0] ID_MEM = ID_W'(0),
  parameter logic [ID_W-1:0] ID_DMA = ID_W'(1),
  parameter logic [ID_W-1:0] ID_AES = ID_W'(2),
  parameter logic [3:0] SINGLE_RGN  = 4'h2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic [ID_W-1:0]     awid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [7:0]          awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [ID_W-1:0]     bid_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic [ID_W-1:0]     arid_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [7:0]          arlen_o,
  output logic [2:0]          arsize_o,
  output logic [1:0]          arburst_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [ID_W-1:0]     rid_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  input  logic                cs_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [LINE_W-1:0]   wdata_i,
  output logic                wfull_o,
  output logic                rd_ready_o,
  output logic [LINE_W-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                rerr_o,
  output logic                werr_o
);

  localparam int BEATS   = LINE_W / DATA_W;
  localparam int CNT_W   = $clog2(BEATS + 1);
  localparam int PTR_W   = $clog2(WFIFO_DEPTH);
  localparam int ENTRY_W = ADDR_W + LINE_W;
  localparam int SIZE    = $clog2(DATA_W / 8);
  localparam logic [7:0] MAX_LEN = 8'(BEATS - 1);

  typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wrState_e;
  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rdState_e;

  function automatic logic [ID_W-1:0] regionId(input logic [3:0] rgn);
    if (rgn == 4'h0)            return ID_MEM;
    else if (rgn == 4'h1)       return ID_DMA;
    else if (rgn == SINGLE_RGN) return ID_AES;
    else                        return ID_MEM;
  endfunction

  wrState_e wrState_q, wrState_d;
  rdState_e rdState_q, rdState_d;

  logic [ENTRY_W-1:0] fifoMem_q [WFIFO_DEPTH];
  logic [PTR_W-1:0]   fifoWrPtr_q, fifoRdPtr_q;
  logic [PTR_W:0]     fifoCount_q;
  logic               fifoEmpty, fifoFull, fifoPush, fifoPop;

  logic [ADDR_W-1:0]  wrAddr_q, rdAddr_q;
  logic [LINE_W-1:0]  wrLine_q, rdata_q;
  logic [CNT_W-1:0]   wrBeat_q, rdBeat_q;
  logic               werr_q, rerr_q, rvalid_q;
  logic               wrSingle, rdSingle, wrLast, rdAccept;
  logic               unusedInputs;

  assign unusedInputs = ^{bid_i, rid_i, rresp_i[0]};

  // A full FIFO still takes a push in the cycle the write engine pops it.
  assign fifoEmpty = (fifoCount_q == '0);
  assign fifoFull  = (fifoCount_q == (PTR_W+1)'(WFIFO_DEPTH));
  assign fifoPop   = (wrState_q == WR_IDLE) && !fifoEmpty;
  assign wfull_o   = fifoFull && !fifoPop;
  assign fifoPush  = cs_i && we_i && !wfull_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifoWrPtr_q <= '0;
      fifoRdPtr_q <= '0;
      fifoCount_q <= '0;
    end else begin
      if (fifoPush) fifoWrPtr_q <= fifoWrPtr_q + PTR_W'(1);
      if (fifoPop)  fifoRdPtr_q <= fifoRdPtr_q + PTR_W'(1);
      case ({fifoPush, fifoPop})
        2'b10:   fifoCount_q <= fifoCount_q + (PTR_W+1)'(1);
        2'b01:   fifoCount_q <= fifoCount_q - (PTR_W+1)'(1);
        default: fifoCount_q <= fifoCount_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifoPush) fifoMem_q[fifoWrPtr_q] <= {addr_i, wdata_i};
  end

  assign wrSingle = (wrAddr_q[19:16] == SINGLE_RGN);
  assign rdSingle = (rdAddr_q[19:16] == SINGLE_RGN);
  assign wrLast   = wrSingle || (wrBeat_q == CNT_W'(BEATS - 1));

  assign awid_o    = regionId(wrAddr_q[19:16]);
  assign awaddr_o  = wrAddr_q;
  assign awlen_o   = wrSingle ? 8'd0 : MAX_LEN;
  assign awsize_o  = 3'(SIZE);
  assign awburst_o = wrSingle ? 2'b00 : 2'b01;
  assign wstrb_o   = '1;
  assign werr_o    = werr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) wrState_q <= WR_IDLE;
    else       wrState_q <= wrState_d;
  end

  always_comb begin
    wrState_d = wrState_q;
    case (wrState_q)
      WR_IDLE: if (!fifoEmpty)           wrState_d = WR_AW;
      WR_AW:   if (awready_i)            wrState_d = WR_W;
      WR_W:    if (wready_i && wrLast)   wrState_d = WR_B;
      WR_B:    if (bvalid_i)             wrState_d = WR_IDLE;
      default:                           wrState_d = WR_IDLE;
    endcase
  end

  always_comb begin
    awvalid_o = (wrState_q == WR_AW);
    wvalid_o  = (wrState_q == WR_W);
    bready_o  = (wrState_q == WR_B);
    wlast_o   = (wrState_q == WR_W) && wrLast;
    wdata_o   = wrLine_q[DATA_W*int'(wrBeat_q) +: DATA_W];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrAddr_q <= '0;
      wrLine_q <= '0;
      wrBeat_q <= '0;
      werr_q   <= 1'b0;
    end else begin
      werr_q <= 1'b0;
      if (fifoPop) begin
        {wrAddr_q, wrLine_q} <= fifoMem_q[fifoRdPtr_q];
        wrBeat_q             <= '0;
      end
      if (wvalid_o && wready_i) wrBeat_q <= wrLast ? '0 : wrBeat_q + CNT_W'(1);
      if (bready_o && bvalid_i && (bresp_i != 2'b00)) werr_q <= 1'b1;
    end
  end

  assign rdAccept  = cs_i && !we_i && rd_ready_o;
  assign arid_o    = regionId(rdAddr_q[19:16]);
  assign araddr_o  = rdAddr_q;
  assign arlen_o   = rdSingle ? 8'd0 : MAX_LEN;
  assign arsize_o  = 3'(SIZE);
  assign arburst_o = rdSingle ? 2'b00 : 2'b01;
  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign rerr_o    = rerr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) rdState_q <= RD_IDLE;
    else       rdState_q <= rdState_d;
  end

  always_comb begin
    rdState_d = rdState_q;
    case (rdState_q)
      RD_IDLE: if (rdAccept)             rdState_d = RD_AR;
      RD_AR:   if (arready_i)            rdState_d = RD_R;
      RD_R:    if (rvalid_i && rlast_i)  rdState_d = RD_IDLE;
      default:                           rdState_d = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_ready_o = (rdState_q == RD_IDLE);
    arvalid_o  = (rdState_q == RD_AR);
    rready_o   = (rdState_q == RD_R);
  end

  // Beats past the line width are accepted on the bus but not stored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdAddr_q <= '0;
      rdBeat_q <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (rdAccept) rdAddr_q <= addr_i;
      if (rdState_q == RD_AR) begin
        rerr_q   <= 1'b0;
        rdBeat_q <= '0;
      end
      if (rready_o && rvalid_i) begin
        if (rdBeat_q < CNT_W'(BEATS)) begin
          rdata_q[DATA_W*int'(rdBeat_q) +: DATA_W] <= rdata_i;
          rdBeat_q <= rdBeat_q + CNT_W'(1);
        end
        rerr_q <= rerr_q | rresp_i[1];
        if (rlast_i) begin
          rvalid_q <= 1'b1;
          rdBeat_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Scoreboard bench for axi_master_bridge: stimulus pushes expected AXI traffic
// and read results into queues, a negedge monitor pops and compares them.
module tb_axi_master_bridge;

  logic         clk;
  logic         rst_i;
  logic [3:0]   awid_o;
  logic [31:0]  awaddr_o;
  logic [7:0]   awlen_o;
  logic [2:0]   awsize_o;
  logic [1:0]   awburst_o;
  logic         awvalid_o, awready_i;
  logic [31:0]  wdata_o;
  logic [3:0]   wstrb_o;
  logic         wlast_o, wvalid_o, wready_i;
  logic [3:0]   bid_i;
  logic [1:0]   bresp_i;
  logic         bvalid_i, bready_o;
  logic [3:0]   arid_o;
  logic [31:0]  araddr_o;
  logic [7:0]   arlen_o;
  logic [2:0]   arsize_o;
  logic [1:0]   arburst_o;
  logic         arvalid_o, arready_i;
  logic [3:0]   rid_i;
  logic [31:0]  rdata_i;
  logic [1:0]   rresp_i;
  logic         rlast_i, rvalid_i, rready_o;
  logic         cs_i, we_i;
  logic [31:0]  addr_i;
  logic [127:0] wdata_i;
  logic         wfull_o, rd_ready_o;
  logic [127:0] rdata_o;
  logic         rvalid_o, rerr_o, werr_o;

  axi_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .LINE_W(128), .ID_W(4), .WFIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .cs_i(cs_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .wfull_o(wfull_o), .rd_ready_o(rd_ready_o), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .rerr_o(rerr_o), .werr_o(werr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int rlastCyc = -100;

  // Ready modes: 0 = held low, 1 = held high, 2 = random each cycle.
  int awMode = 1;
  int wMode  = 1;
  int arMode = 1;
  bit rGap   = 1'b0;

  logic [48:0]  awExpQ[$];
  logic [36:0]  wExpQ[$];
  logic [48:0]  arExpQ[$];
  logic [128:0] rdExpQ[$];
  logic [33:0]  rBeatQ[$];
  logic [1:0]   bRespQ[$];
  logic         werrExpQ[$];

  logic [48:0]  awE, arE;
  logic [36:0]  wE;
  logic [128:0] rdE;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [199:0] actual,
                             input logic [199:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic pickReady(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    #1;
    awready_i = pickReady(awMode);
    wready_i  = pickReady(wMode);
    arready_i = pickReady(arMode);
  end

  // Write response slave: answers each completed W burst with the next queued bresp.
  initial begin
    bvalid_i = 1'b0;
    bresp_i  = 2'b00;
    bid_i    = '0;
    forever begin
      @(negedge clk);
      if (!rst_i && wvalid_o && wready_i && wlast_o) begin
        @(posedge clk);
        #1;
        bvalid_i = 1'b1;
        bresp_i  = 2'b00;
        if (bRespQ.size() != 0) bresp_i = bRespQ.pop_front();
        @(posedge clk);
        #1;
        bvalid_i = 1'b0;
        bresp_i  = 2'b00;
      end
    end
  end

  // Read data slave: plays arlen+1 queued beats, optionally with idle gaps.
  initial begin
    int rN, rK;
    logic [33:0] rBeat;
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    rdata_i  = '0;
    rresp_i  = '0;
    rid_i    = '0;
    forever begin
      @(negedge clk);
      if (!rst_i && arvalid_o && arready_i) begin
        rN = int'(arlen_o) + 1;
        rK = 0;
        @(posedge clk);
        while (rK < rN) begin
          #1;
          if (rGap && $urandom_range(0, 3) == 0) begin
            rvalid_i = 1'b0;
            rlast_i  = 1'b0;
          end else begin
            rBeat = '0;
            if (rBeatQ.size() != 0) rBeat = rBeatQ.pop_front();
            rvalid_i = 1'b1;
            rresp_i  = rBeat[33:32];
            rdata_i  = rBeat[31:0];
            rlast_i  = (rK == rN - 1);
            rK++;
          end
          @(posedge clk);
        end
        #1;
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        rdata_i  = '0;
        rresp_i  = '0;
      end
    end
  end

  // Monitor: every handshake or result pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (awvalid_o && awready_i) begin
        checkOutput("aw_expected", awExpQ.size() != 0, 1);
        if (awExpQ.size() != 0) begin
          awE = awExpQ.pop_front();
          checkOutput("aw_fields", {awid_o, awaddr_o, awlen_o, awsize_o, awburst_o}, awE);
        end
      end
      if (wvalid_o && wready_i) begin
        checkOutput("w_expected", wExpQ.size() != 0, 1);
        if (wExpQ.size() != 0) begin
          wE = wExpQ.pop_front();
          checkOutput("w_beat", {wdata_o, wstrb_o, wlast_o}, wE);
        end
      end
      if (arvalid_o && arready_i) begin
        checkOutput("ar_expected", arExpQ.size() != 0, 1);
        if (arExpQ.size() != 0) begin
          arE = arExpQ.pop_front();
          checkOutput("ar_fields", {arid_o, araddr_o, arlen_o, arsize_o, arburst_o}, arE);
        end
      end
      if (rvalid_i && rready_o && rlast_i) rlastCyc = cyc;
      if (rvalid_o) begin
        checkOutput("rvalid_latency", cyc - rlastCyc, 1);
        checkOutput("rd_expected", rdExpQ.size() != 0, 1);
        if (rdExpQ.size() != 0) begin
          rdE = rdExpQ.pop_front();
          checkOutput("rd_line_err", {rdata_o, rerr_o}, rdE);
        end
      end
      if (werr_o) begin
        checkOutput("werr_expected", werrExpQ.size() != 0, 1);
        if (werrExpQ.size() != 0) void'(werrExpQ.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One CPU request cycle; called at posedge+1.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [127:0] line);
    cs_i    = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = line;
    @(posedge clk);
    #1;
    cs_i = 1'b0;
    we_i = 1'b0;
  endtask

  task automatic expectWrite(input logic [31:0] addr, input logic [127:0] line,
                             input logic [3:0] expId, input logic single,
                             input logic [1:0] bresp, input logic abandon);
    logic [127:0] tmp;
    int beats;
    tmp   = line;
    beats = single ? 1 : 4;
    awExpQ.push_back({expId, addr, single ? 8'd0 : 8'd3, 3'd2, single ? 2'b00 : 2'b01});
    if (abandon) begin
      wExpQ.push_back({tmp[31:0], 4'hF, 1'b0});
    end else begin
      for (int k = 0; k < beats; k++)
        wExpQ.push_back({tmp[k*32 +: 32], 4'hF, k == beats - 1});
      bRespQ.push_back(bresp);
      if (bresp != 2'b00) werrExpQ.push_back(1'b1);
    end
  endtask

  task automatic cpuWrite(input logic [31:0] addr, input logic [127:0] line,
                          input logic [3:0] expId, input logic single,
                          input logic [1:0] bresp, input logic expAccept,
                          input logic abandon);
    checkOutput("wfull_before_push", wfull_o, !expAccept);
    if (expAccept) expectWrite(addr, line, expId, single, bresp, abandon);
    applyStimulus(1'b1, addr, line);
  endtask

  task automatic cpuWriteWhenFree(input logic [31:0] addr, input logic [127:0] line,
                                  input logic [3:0] expId);
    bit freed;
    freed = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (!wfull_o) begin
        freed = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("wfull_release", freed, 1);
    expectWrite(addr, line, expId, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b1, addr, line);
  endtask

  task automatic cpuRead(input logic [31:0] addr, input logic [3:0] expId,
                         input logic single, input logic [127:0] beatData,
                         input logic [3:0] errMask, input logic [127:0] expLine,
                         input logic expErr);
    logic [127:0] tmp;
    bit ready;
    int beats;
    tmp   = beatData;
    beats = single ? 1 : 4;
    ready = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (rd_ready_o) begin
        ready = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("rd_ready_wait", ready, 1);
    arExpQ.push_back({expId, addr, single ? 8'd0 : 8'd3, 3'd2, single ? 2'b00 : 2'b01});
    for (int k = 0; k < beats; k++)
      rBeatQ.push_back({errMask[k] ? 2'b10 : 2'b00, tmp[k*32 +: 32]});
    rdExpQ.push_back({expLine, expErr});
    applyStimulus(1'b0, addr, '0);
    checkOutput("rd_ready_busy", rd_ready_o, 0);
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (awExpQ.size() == 0 && wExpQ.size() == 0 && arExpQ.size() == 0 &&
          rdExpQ.size() == 0 && rBeatQ.size() == 0 && bRespQ.size() == 0 &&
          werrExpQ.size() == 0 && !awvalid_o && !wvalid_o && !bready_o &&
          !bvalid_i && !rvalid_i && rd_ready_o) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_done", done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seenW;
    rst_i     = 1'b1;
    cs_i      = 1'b0;
    we_i      = 1'b0;
    addr_i    = '0;
    wdata_i   = '0;
    awready_i = 1'b0;
    wready_i  = 1'b0;
    arready_i = 1'b0;
    idle(3);
    rst_i = 1'b0;

    checkOutput("reset_wfull", wfull_o, 0);
    checkOutput("reset_rd_ready", rd_ready_o, 1);
    checkOutput("reset_valids", {awvalid_o, wvalid_o, wlast_o, bready_o, arvalid_o, rready_o}, 6'b0);
    checkOutput("reset_pulses", {rvalid_o, rerr_o, werr_o}, 3'b0);
    checkOutput("reset_rdata", rdata_o, 128'h0);

    $display("[TB] four-beat write to region 0");
    cpuWrite(32'h0000_0010, 128'h00004444_00003333_00002222_00001111, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] single-beat write to region 2 with error response");
    cpuWrite(32'h0002_0004, 128'hDEAD0000_BEEF0000_12345678_9ABCDEF0, 4'd2, 1'b1, 2'b10, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] single-beat read from region 2");
    cpuRead(32'h0002_0000, 4'd2, 1'b1, 128'h0000CAFE, 4'b0000, 128'h0000CAFE, 1'b0);
    waitDrain();

    $display("[TB] read with error on beat 2, then clean read");
    cpuRead(32'h0000_0040, 4'd0, 1'b0, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 4'b0100,
            128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 1'b1);
    cpuRead(32'h0003_0080, 4'd0, 1'b0, 128'h44444444_33333333_22222222_11111111, 4'b0000,
            128'h44444444_33333333_22222222_11111111, 1'b0);
    waitDrain();

    $display("[TB] fill write FIFO behind a stalled AW");
    awMode = 0;
    cpuWrite(32'h0000_0100, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0);
    idle(3);
    cpuWrite(32'h0000_0200, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0);
    cpuWrite(32'h0000_0300, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0);
    cpuWrite(32'h0004_0400, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0);
    cpuWrite(32'h0001_0500, 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0, 4'd1, 1'b0, 2'b00, 1'b1, 1'b0);
    cpuWrite(32'h0000_0600, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    awMode = 1;
    cpuWriteWhenFree(32'h0001_0700, 128'h67676767_66666666_65656565_64646464, 4'd1);
    checkOutput("wfull_after_push_pop", wfull_o, 1);
    waitDrain();

    $display("[TB] reset in the middle of a W burst");
    wMode = 0;
    cpuWrite(32'h0000_0800, 128'h88888883_88888882_88888881_88888880, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1);
    seenW = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (wvalid_o) begin
        seenW = 1'b1;
        break;
      end
    end
    checkOutput("w_phase_reached", seenW, 1);
    wMode = 1;
    @(negedge clk);
    wMode = 0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_wvalid", wvalid_o, 0);
    checkOutput("rst_mid_wfull", wfull_o, 0);
    checkOutput("rst_mid_idle", {awvalid_o, bready_o, arvalid_o, rready_o}, 4'b0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    wMode = 1;
    cpuWrite(32'h0000_0900, 128'h99999993_99999992_99999991_99999990, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] concurrent read and write to region 1 with random stalls");
    awMode = 2;
    wMode  = 2;
    arMode = 2;
    rGap   = 1'b1;
    cpuWrite(32'h0001_0020, 128'h0BADF00D_FEEDFACE_13572468_01234567, 4'd1, 1'b0, 2'b00, 1'b1, 1'b0);
    cpuRead(32'h0001_0030, 4'd1, 1'b0, 128'h55AA55AA_89ABCDEF_76543210_FACEB00C, 4'b0000,
            128'h55AA55AA_89ABCDEF_76543210_FACEB00C, 1'b0);
    waitDrain();

    checkOutput("final_aw_queue", awExpQ.size(), 0);
    checkOutput("final_w_queue", wExpQ.size(), 0);
    checkOutput("final_rd_queue", rdExpQ.size(), 0);
    checkOutput("final_werr_queue", werrExpQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
